frame_pixel_streamer: RTL
=========================

Name: frame_pixel_streamer

Overview:
- Reads the finished dithered frame out of on-chip pixel RAM in raster order and presents it as a valid/ready pixel stream, tagged with (x, y) and a last flag.
- Sits between the frame buffer's read port and the downstream output sink (UART/VGA packer).
- It is the consumer counterpart of the pixel-traversal address counter: it generates its own read addresses and absorbs RAM read latency under backpressure without losing pixels.

Parameters:
- IMAGEX, 64, frame width in pixels; power of two.
- IMAGEY, 64, frame height in pixels; power of two.
- IMAGE_SIZE, IMAGEX*IMAGEY, pixels per frame.
- IMAGEXlog2, $clog2(IMAGEX), x coordinate width.
- IMAGEYlog2, $clog2(IMAGEY), y coordinate width.
- IMAGE_ADDR_WIDTH, $clog2(IMAGE_SIZE), RAM address width.
- RGB_SIZE, 8, pixel data width.
- READ_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data; legal values 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to stream one frame; honoured only in IDLE
- mem_rd_en  out  1  RAM read strobe
- mem_rd_addr  out  IMAGE_ADDR_WIDTH  RAM read address, = {y, x}
- mem_rd_data  in  RGB_SIZE  RAM read data, valid READ_LATENCY cycles after mem_rd_en
- pix_data  out  RGB_SIZE  output pixel
- pix_x  out  IMAGEXlog2  column of pix_data
- pix_y  out  IMAGEYlog2  row of pix_data
- pix_last  out  1  high with the final pixel (x=IMAGEX-1, y=IMAGEY-1)
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  sink accepts pixel
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the final pixel handshake

Behaviour:
- Reset (rst=0 at posedge):
  - State goes to IDLE.
  - All outputs 0: mem_rd_en, mem_rd_addr, pix_*, busy, done.
  - FIFO is emptied; the read-address counter and in-flight counter are cleared.
  - The latency shift register is cleared, so RAM data still returning from before reset is discarded.
  - Reset mid-frame aborts the frame; no done pulse is produced.
- State machine:
  - IDLE: start=1 -> RUN; address counter cleared; busy=1 next cycle.
  - RUN: issues reads. After the read for address IMAGE_SIZE-1 is issued -> DRAIN.
  - DRAIN: no reads. When the pix_last handshake occurs -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
  - start outside IDLE is ignored.
- Read issue (registered):
  - mem_rd_en is asserted in RUN when fifo_count + inflight - pop <= READ_LATENCY, where pop = pix_valid & pix_ready.
  - The address increments by 1 per issued read and does not wrap within a frame.
- Latency tracking:
  - A READ_LATENCY-deep valid shift register tags each issued read.
  - When the tag emerges, mem_rd_data is written into the FIFO together with the x/y/last derived from the delayed address.
  - inflight = number of tags currently in the shift register.
- FIFO:
  - Depth READ_LATENCY+1, first-word-fall-through.
  - pix_valid = FIFO non-empty; pix_data/pix_x/pix_y/pix_last come from the head entry.
  - Push and pop in the same cycle are allowed, and the count is unchanged.
  - The credit rule above guarantees no overflow; an overflow is a design error (simulation assertion).
- Output stability: while pix_valid=1 and pix_ready=0, all pix_* outputs hold unchanged.
- Timing:
  - start seen at cycle 0 -> first mem_rd_en at cycle 1 (addr 0) -> first pix_valid at cycle 2+READ_LATENCY.
  - With pix_ready held 1, the block sustains one pixel per cycle, no bubbles.
  - Full frame: done at cycle IMAGE_SIZE+2+READ_LATENCY.
- Ordering: pixels are emitted strictly in address order 0..IMAGE_SIZE-1. Pixel i carries x=i mod IMAGEX and y=i/IMAGEX.
- Back-to-back: start in the cycle after done (IDLE) launches a new frame beginning at addr 0.

Test Plan:
- 64x64 frame, RAM mem[i]=i[7:0], pix_ready=1 -> 4096 pixels in order, pix_data=i[7:0]; pix_last only at (63,63); first pix_valid at cycle 3; done at cycle 4099; busy falls with done.
- Same frame, pix_ready random 50% -> identical 4096-pixel sequence; pix_* stable while stalled; assertion shows FIFO never overflows.
- pix_ready=0 for 20 cycles starting at pixel 100 -> mem_rd_en deasserts within READ_LATENCY+1 cycles; no pixel lost or duplicated; one pixel per cycle resumes when pix_ready returns to 1.
- start pulsed at pixel 500 while busy -> ignored; frame completes normally with a single done pulse.
- rst=0 at pixel 1000 with reads in flight -> all outputs 0 the next cycle, no stale pix_valid afterwards; a new start streams from addr 0, pix_data=0x00.
- READ_LATENCY=2, IMAGEX=IMAGEY=4, two back-to-back starts, pix_ready=1 -> 16 pixels per frame; first pix_valid at cycle 4; done at cycle 20; second frame repeats the identical sequence.

Source files
------------

// File: rtl/frame_pixel_streamer_if.sv
// frame_pixel_streamer_if
//   Bundles the two buses of the frame streamer.
//   RAM read port : mem_rd_en, mem_rd_addr (streamer -> RAM), mem_rd_data (RAM -> streamer)
//   Pixel stream  : pix_data, pix_x, pix_y, pix_last, pix_valid (streamer -> sink),
//                   pix_ready (sink -> streamer)
//   master = streamer side, slave = RAM / sink side.
interface frame_pixel_streamer_if #(
   parameter int RGB_SIZE         = 8,
   parameter int IMAGEXlog2       = 6,
   parameter int IMAGEYlog2       = 6,
   parameter int IMAGE_ADDR_WIDTH = 12
);
   logic                        mem_rd_en;
   logic [IMAGE_ADDR_WIDTH-1:0] mem_rd_addr;
   logic [RGB_SIZE-1:0]         mem_rd_data;
   logic [RGB_SIZE-1:0]         pix_data;
   logic [IMAGEXlog2-1:0]       pix_x;
   logic [IMAGEYlog2-1:0]       pix_y;
   logic                        pix_last;
   logic                        pix_valid;
   logic                        pix_ready;

   modport master (
      output mem_rd_en, mem_rd_addr,
      input  mem_rd_data,
      output pix_data, pix_x, pix_y, pix_last, pix_valid,
      input  pix_ready
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr,
      output mem_rd_data,
      input  pix_data, pix_x, pix_y, pix_last, pix_valid,
      output pix_ready
   );
endinterface

// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer
//   Streams a finished frame out of pixel RAM in raster order as a valid/ready
//   pixel stream tagged with (x, y) and last. Generates its own read addresses
//   and absorbs RAM read latency in a small FWFT FIFO so backpressure never
//   loses a pixel.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   start      one-cycle frame request, honoured only when idle
//   bus        frame_pixel_streamer_if.master: RAM read port + pixel stream
//   busy       frame in progress
//   done       one-cycle pulse after the final pixel handshake
module frame_pixel_streamer #(
   parameter int IMAGEX           = 64,
   parameter int IMAGEY           = 64,
   parameter int IMAGE_SIZE       = IMAGEX*IMAGEY,
   parameter int IMAGEXlog2       = $clog2(IMAGEX),
   parameter int IMAGEYlog2       = $clog2(IMAGEY),
   parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
   parameter int RGB_SIZE         = 8,
   parameter int READ_LATENCY     = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   frame_pixel_streamer_if.master bus,
   output logic                   busy,
   output logic                   done
);
   localparam int AW    = IMAGE_ADDR_WIDTH;
   localparam int L     = READ_LATENCY;
   localparam int DEPTH = L + 1;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);

   typedef struct packed {
      logic [RGB_SIZE-1:0]   data;
      logic [IMAGEXlog2-1:0] x;
      logic [IMAGEYlog2-1:0] y;
      logic                  last;
   } pix_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t               state, state_n;
   logic [AW-1:0]        rd_addr;
   logic                 rd_en, credit, push, pop, valid;
   // vld_pipe[0] is the read issued this cycle; vld_pipe[L] is the tag whose
   // data is on mem_rd_data now. addr_pipe carries the matching address.
   logic [L:0]           vld_pipe;
   logic [L-1:0]         vld_q;
   logic [L:0][AW-1:0]   addr_pipe;
   logic [L-1:0][AW-1:0] addr_q;
   logic [CW-1:0]        inflight, fifo_cnt;
   logic [PW-1:0]        wr_ptr, rd_ptr;
   pix_t                 fifo_mem [DEPTH];
   pix_t                 head, wr_entry;

   function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      vld_pipe  = {vld_q, rd_en};
      addr_pipe = {addr_q, rd_addr};
      inflight  = '0;
      for (int i = 1; i <= L; i++) inflight += CW'(vld_pipe[i]);
   end

   assign valid = (fifo_cnt != '0);
   assign pop   = valid & bus.pix_ready;
   assign push  = vld_pipe[L];
   assign head  = fifo_mem[rd_ptr];

   // Credit check: every occupied or in-flight slot counts against the FIFO,
   // so a read is issued only if its data is guaranteed a slot on arrival.
   assign credit = (int'(fifo_cnt) + int'(inflight) - int'(pop)) <= L;
   assign rd_en  = (state == RUN) && credit;

   always_comb begin
      wr_entry.data = bus.mem_rd_data;
      wr_entry.x    = addr_pipe[L][IMAGEXlog2-1:0];
      wr_entry.y    = addr_pipe[L][AW-1:IMAGEXlog2];
      wr_entry.last = (addr_pipe[L] == LAST_ADDR);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (rd_en && rd_addr == LAST_ADDR) state_n = DRAIN;
         DRAIN:   if (pop && head.last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         rd_addr  <= '0;
         vld_q    <= '0;
         addr_q   <= '0;
         fifo_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         state  <= state_n;
         vld_q  <= vld_pipe[L-1:0];
         addr_q <= addr_pipe[L-1:0];
         if (state == IDLE && start) rd_addr <= '0;
         else if (rd_en)             rd_addr <= rd_addr + AW'(1);
         if (push) wr_ptr <= ptr_nxt(wr_ptr);
         if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
         assert (!(push && !pop && fifo_cnt == CW'(DEPTH)));
      end
   end

   // Storage needs no reset: reads are gated by fifo_cnt.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= wr_entry;
   end

   assign bus.mem_rd_en   = rd_en;
   assign bus.mem_rd_addr = rd_addr;
   assign bus.pix_valid   = valid;
   // Outputs forced to zero when empty so stale FIFO entries never show.
   assign bus.pix_data    = valid ? head.data : '0;
   assign bus.pix_x       = valid ? head.x    : '0;
   assign bus.pix_y       = valid ? head.y    : '0;
   assign bus.pix_last    = valid & head.last;
   assign busy            = (state == RUN) || (state == DRAIN);
   assign done            = (state == DONE);
endmodule
